life_neighbor_window: RTL and testbench



---
 rtl/life_neighbor_window_if.sv | 27 ++
 rtl/life_neighbor_window.sv | 190 +++++++++++++++++++
 tb/tb_life_neighbor_window.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/life_neighbor_window_if.sv
// Load/emit handshake bundle for life_neighbor_window: serial cell load in,
// per-cell centre plus packed 3x3 neighbourhood out.
interface life_neighbor_window_if #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
);
  logic                      in_valid;
  logic                      in_cell;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_center;
  logic [7:0]                out_neighbors;
  logic [$clog2(WIDTH)-1:0]  out_x;
  logic [$clog2(HEIGHT)-1:0] out_y;
  logic                      frame_done;

  modport master (
    output in_valid, in_cell, out_ready,
    input  in_ready, out_valid, out_center, out_neighbors, out_x, out_y, frame_done
  );

  modport slave (
    input  in_valid, in_cell, out_ready,
    output in_ready, out_valid, out_center, out_neighbors, out_x, out_y, frame_done
  );
endinterface

// File: rtl/life_neighbor_window.sv
// Frame-buffered Game-of-Life neighbourhood generator: loads a WIDTHxHEIGHT grid
// serially, then replays each cell with its 8 neighbours. Define LIFE_WINDOW_TORUS_EN for wrapped edges.
module life_neighbor_window #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  life_neighbor_window_if.slave bus
);
  localparam int CELLS = WIDTH * HEIGHT;
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int IW    = $clog2(CELLS);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  typedef enum logic {ST_LOAD = 1'b0, ST_EMIT = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic [XW-1:0]     x_r, x_next_s;
  logic [YW-1:0]     y_r, y_next_s;
  logic [CELLS-1:0]  buf_r, buf_next_s;
  logic [IW-1:0]     wr_idx_s;
  logic              wr_en_s, present_s, last_s;
  logic              out_valid_r, out_valid_next_s;
  logic              frame_done_r, frame_done_next_s;
  logic              out_center_r, center_s;
  logic [7:0]        out_neighbors_r, window_s;
  logic [XW-1:0]     out_x_r;
  logic [YW-1:0]     out_y_r;
  int                win_cx_s, win_cy_s;

  // Out-of-grid coordinates either wrap or read as a dead border.
  function automatic logic cell_at(input logic [CELLS-1:0] b, input int cx, input int cy);
    int          wx;
    int          wy;
    logic [IW-1:0] idx;
    logic        val;
`ifdef LIFE_WINDOW_TORUS_EN
    if (cx < 32'sd0)        wx = cx + WIDTH;
    else if (cx >= WIDTH)   wx = cx - WIDTH;
    else                    wx = cx;
    if (cy < 32'sd0)        wy = cy + HEIGHT;
    else if (cy >= HEIGHT)  wy = cy - HEIGHT;
    else                    wy = cy;
    idx = IW'(wy * WIDTH + wx);
    val = b[idx];
`else
    wx = cx;
    wy = cy;
    if ((wx < 32'sd0) || (wx >= WIDTH) || (wy < 32'sd0) || (wy >= HEIGHT)) begin
      idx = {IW{1'b0}};
      val = 1'b0;
    end else begin
      idx = IW'(wy * WIDTH + wx);
      val = b[idx];
    end
`endif
    return val;
  endfunction

  assign last_s   = (x_r == XMAX) && (y_r == YMAX);
  assign wr_idx_s = IW'(int'(y_r) * WIDTH + int'(x_r));
  assign win_cx_s = int'(x_next_s);
  assign win_cy_s = int'(y_next_s);

  // Next-state, counter and output-load decisions.
  always_comb begin
    state_next_s      = state_r;
    x_next_s          = x_r;
    y_next_s          = y_r;
    wr_en_s           = 1'b0;
    present_s         = 1'b0;
    out_valid_next_s  = out_valid_r;
    frame_done_next_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        out_valid_next_s = 1'b0;
        if (bus.in_valid) begin
          wr_en_s = 1'b1;
          if (last_s) begin
            state_next_s     = ST_EMIT;
            x_next_s         = {XW{1'b0}};
            y_next_s         = {YW{1'b0}};
            present_s        = 1'b1;
            out_valid_next_s = 1'b1;
          end else if (x_r == XMAX) begin
            x_next_s = {XW{1'b0}};
            y_next_s = y_r + YW'(1);
          end else begin
            x_next_s = x_r + XW'(1);
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          if (last_s) begin
            state_next_s      = ST_LOAD;
            x_next_s          = {XW{1'b0}};
            y_next_s          = {YW{1'b0}};
            out_valid_next_s  = 1'b0;
            frame_done_next_s = 1'b1;
          end else if (x_r == XMAX) begin
            x_next_s  = {XW{1'b0}};
            y_next_s  = y_r + YW'(1);
            present_s = 1'b1;
          end else begin
            x_next_s  = x_r + XW'(1);
            present_s = 1'b1;
          end
        end else begin
          present_s = 1'b0;
        end
      end
      default: begin
        state_next_s     = ST_LOAD;
        x_next_s         = {XW{1'b0}};
        y_next_s         = {YW{1'b0}};
        out_valid_next_s = 1'b0;
      end
    endcase
  end

  // Forward the in-flight load write so the first window sees the final cell.
  always_comb begin
    buf_next_s = buf_r;
    if (wr_en_s) begin
      buf_next_s[wr_idx_s] = bus.in_cell;
    end else begin
      buf_next_s = buf_r;
    end
  end

  // Centre and neighbourhood of the cell about to be presented.
  always_comb begin
    center_s = cell_at(buf_next_s, win_cx_s, win_cy_s);
    window_s = {cell_at(buf_next_s, win_cx_s + 32'sd1, win_cy_s + 32'sd1),
                cell_at(buf_next_s, win_cx_s,          win_cy_s + 32'sd1),
                cell_at(buf_next_s, win_cx_s - 32'sd1, win_cy_s + 32'sd1),
                cell_at(buf_next_s, win_cx_s + 32'sd1, win_cy_s),
                cell_at(buf_next_s, win_cx_s - 32'sd1, win_cy_s),
                cell_at(buf_next_s, win_cx_s + 32'sd1, win_cy_s - 32'sd1),
                cell_at(buf_next_s, win_cx_s,          win_cy_s - 32'sd1),
                cell_at(buf_next_s, win_cx_s - 32'sd1, win_cy_s - 32'sd1)};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= ST_LOAD;
    else          state_r <= state_next_s;
  end

  // Counters, frame buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_r             <= {XW{1'b0}};
      y_r             <= {YW{1'b0}};
      buf_r           <= {CELLS{1'b0}};
      out_valid_r     <= 1'b0;
      frame_done_r    <= 1'b0;
      out_center_r    <= 1'b0;
      out_neighbors_r <= 8'h00;
      out_x_r         <= {XW{1'b0}};
      out_y_r         <= {YW{1'b0}};
    end else begin
      x_r          <= x_next_s;
      y_r          <= y_next_s;
      buf_r        <= buf_next_s;
      out_valid_r  <= out_valid_next_s;
      frame_done_r <= frame_done_next_s;
      if (present_s) begin
        out_center_r    <= center_s;
        out_neighbors_r <= window_s;
        out_x_r         <= x_next_s;
        out_y_r         <= y_next_s;
      end
    end
  end

  assign bus.in_ready      = (state_r == ST_LOAD) & reset_n;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_center    = out_center_r;
  assign bus.out_neighbors = out_neighbors_r;
  assign bus.out_x         = out_x_r;
  assign bus.out_y         = out_y_r;
  assign bus.frame_done    = frame_done_r;
endmodule

// File: tb/tb_life_neighbor_window.sv
// Directed bench for life_neighbor_window on a 4x4 grid: table of hand-computed
// windows plus backpressure, gapped-load and mid-frame reset sequences.
module tb_life_neighbor_window;
  localparam int W = 4;
  localparam int H = 4;
`ifdef LIFE_WINDOW_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  typedef struct {
    logic [15:0] grid;
    int          x;
    int          y;
    logic        c;
    logic [7:0]  nb;
    logic [7:0]  nbt;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   got_x [16];
  int   got_y [16];
  logic got_c [16];
  logic [7:0] got_nb [16];
  vec_t tbl [19];

  life_neighbor_window_if #(.WIDTH(W), .HEIGHT(H)) bus ();
  life_neighbor_window #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {bus.out_valid, bus.out_center, bus.out_neighbors, bus.out_x, bus.out_y};
  endfunction

  task automatic load_frame(input logic [15:0] grid, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i == 15) check("pre_last_out_valid", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_cell  = grid[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("out_valid_rise", 32'(bus.out_valid), 32'd1);
    check("first_xy", 32'({bus.out_x, bus.out_y}), 32'd0);
    check("in_ready_emit", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic emit_frame(input int stall_at);
    int beats, cyc, fd;
    bit stalled;
    logic [13:0] snap;
    beats = 0; cyc = 0; fd = 0; stalled = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got_x[i] = -1; got_y[i] = -1; got_c[i] = 1'b0; got_nb[i] = 8'h00;
    end
    while (beats < 16 && cyc < 200) begin
      if (bus.frame_done) fd++;
      if (bus.out_valid && beats == stall_at && !stalled) begin
        stalled = 1'b1;
        snap = outs();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_hold", 32'(outs()), 32'(snap));
        end
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_x[beats]  = int'(bus.out_x);
        got_y[beats]  = int'(bus.out_y);
        got_c[beats]  = bus.out_center;
        got_nb[beats] = bus.out_neighbors;
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    check("beat_count", 32'(beats), 32'd16);
    check("done_pulse", 32'(bus.frame_done), 32'd1);
    check("done_out_valid", 32'(bus.out_valid), 32'd0);
    check("done_in_ready", 32'(bus.in_ready), 32'd1);
    if (bus.frame_done) fd++;
    @(negedge clk);
    if (bus.frame_done) fd++;
    check("done_count", 32'(fd), 32'd1);
  endtask

  task automatic check_frame(input logic [15:0] grid);
    logic ok;
    logic [15:0] cs;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (got_x[i] != i % 4 || got_y[i] != i / 4) ok = 1'b0;
      cs[i] = got_c[i];
    end
    check("beat_order", 32'(ok), 32'd1);
    check("centers", 32'(cs), 32'(grid));
  endtask

  initial begin
    int beats, cyc;
    logic [15:0] last_grid;
    // grid bit i is cell (i%4, i/4)
    tbl[0]  = '{16'h0020, 0, 0, 1'b0, 8'h80, 8'h80};
    tbl[1]  = '{16'h0020, 2, 2, 1'b0, 8'h01, 8'h01};
    tbl[2]  = '{16'h0020, 1, 1, 1'b1, 8'h00, 8'h00};
    tbl[3]  = '{16'h0020, 3, 3, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{16'h0020, 1, 0, 1'b0, 8'h40, 8'h40};
    tbl[5]  = '{16'h0020, 0, 1, 1'b0, 8'h10, 8'h10};
    tbl[6]  = '{16'hFFFF, 0, 0, 1'b1, 8'hD0, 8'hFF};
    tbl[7]  = '{16'hFFFF, 1, 1, 1'b1, 8'hFF, 8'hFF};
    tbl[8]  = '{16'hFFFF, 3, 3, 1'b1, 8'h0B, 8'hFF};
    tbl[9]  = '{16'hFFFF, 3, 0, 1'b1, 8'h68, 8'hFF};
    tbl[10] = '{16'hFFFF, 0, 3, 1'b1, 8'h16, 8'hFF};
    tbl[11] = '{16'h0001, 3, 3, 1'b0, 8'h00, 8'h80};
    tbl[12] = '{16'h0001, 1, 1, 1'b0, 8'h01, 8'h01};
    tbl[13] = '{16'h0001, 1, 0, 1'b0, 8'h08, 8'h08};
    tbl[14] = '{16'h0001, 0, 3, 1'b0, 8'h00, 8'h40};
    tbl[15] = '{16'h0001, 3, 0, 1'b0, 8'h00, 8'h10};
    tbl[16] = '{16'h8421, 1, 0, 1'b0, 8'h48, 8'h48};
    tbl[17] = '{16'h8421, 1, 1, 1'b1, 8'h81, 8'h81};
    tbl[18] = '{16'h8421, 3, 3, 1'b1, 8'h01, 8'h81};

    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_cell = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    last_grid = 16'h0000;
    for (int v = 0; v < 19; v++) begin
      if (v == 0 || tbl[v].grid != last_grid) begin
        load_frame(tbl[v].grid, 1'b0);
        emit_frame(-1);
        check_frame(tbl[v].grid);
        last_grid = tbl[v].grid;
      end
      check($sformatf("center_v%0d", v), 32'(got_c[tbl[v].y * 4 + tbl[v].x]), 32'(tbl[v].c));
      check($sformatf("nb_v%0d", v), 32'(got_nb[tbl[v].y * 4 + tbl[v].x]),
            32'(TORUS ? tbl[v].nbt : tbl[v].nb));
    end

    // Backpressure on cell (2,1), beat index 6
    load_frame(16'h8421, 1'b0);
    emit_frame(6);
    check_frame(16'h8421);
    check("bp_nb_2_1", 32'(got_nb[6]), 32'h48);

    // Gapped load
    load_frame(16'h0020, 1'b1);
    emit_frame(-1);
    check_frame(16'h0020);
    check("gap_nb_0_0", 32'(got_nb[0]), 32'h80);

    // Reset after the 5th output beat
    load_frame(16'h8421, 1'b0);
    beats = 0; cyc = 0;
    while (beats < 5 && cyc < 100) begin
      if (bus.out_valid && bus.out_ready) beats++;
      @(negedge clk);
      cyc++;
    end
    check("mid_beats", 32'(beats), 32'd5);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rel_out_valid", 32'(bus.out_valid), 32'd0);
    load_frame(16'h0020, 1'b0);
    emit_frame(-1);
    check_frame(16'h0020);
    check("post_rst_nb_2_2", 32'(got_nb[10]), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
